mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Issues one memory transaction at a time: registered request out, wait for `mem_ack`, return a registered one-cycle `ready` pulse to the winning requester.
- Data port has fixed priority. An optional starvation guard exists for fetch.
- Supports discarding an in-flight fetch on pipeline flush.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (used only with the optional feature); legal range 1..15

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request; held with `i_addr` stable until `i_ready` or flush
- i_addr  input  ADDR_W  fetch address
- i_flush  input  1  pipeline redirect; cancels the pending fetch
- i_ready  output  1  one-cycle pulse: `i_rdata` valid
- i_rdata  output  DATA_W  fetched word, registered
- d_req  input  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ready`
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_ready  output  1  one-cycle pulse: load data valid / store done
- d_rdata  output  DATA_W  load data, registered
- mem_req  output  1  memory request, held until `mem_ack`
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_ack  input  1  one-cycle completion from memory; `mem_rdata` valid in the same cycle
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset (sync) returns every output to 0 and the FSM to IDLE.
- FSM states are IDLE, WAIT_I, WAIT_D, DROP, RESP.
- IDLE:
  - `d_req` → latch `d_we`/`d_addr`/`d_wdata` onto the `mem_*` outputs, set `mem_req`=1, go to WAIT_D.
  - else `i_req` and not `i_flush` → `mem_we`=0, `mem_addr`=`i_addr`, `mem_req`=1, go to WAIT_I.
  - `mem_ack` is ignored.
- WAIT_D:
  - Hold `mem_*` stable.
  - On `mem_ack`: `mem_req`←0, `d_rdata`←`mem_rdata` (loads only; unchanged on stores), `d_ready`←1, go to RESP.
- WAIT_I:
  - On `mem_ack` with `i_flush`=0: `i_rdata`←`mem_rdata`, `i_ready`←1, go to RESP.
  - `i_flush` high before or with `mem_ack` → go to DROP, or straight to RESP with `i_ready` suppressed if `mem_ack` arrives in the same cycle.
- DROP:
  - Keep `mem_req` until `mem_ack` (transactions are never abandoned).
  - On `mem_ack`: `mem_req`←0, no ready pulse, go to RESP.
- RESP:
  - Both `ready` outputs return to 0. Requests are ignored this cycle so a requester dropping `req` after `ready` is never double-serviced.
  - Next state is IDLE.
- Latency: request sampled in IDLE at edge t gives `mem_req` high in cycle t+1. With `mem_ack` in cycle t+1+k, `ready` is high in cycle t+2+k. Minimum is 2 cycles from request to ready (k=0); minimum spacing between grants is 3 cycles.
- Simultaneous `i_req` and `d_req` in IDLE: data wins. Fetch stays pending, with no loss.
- `i_flush` in IDLE: fetch is not granted that cycle.
- `i_flush` in WAIT_D or RESP: no effect.
- Reset mid-transaction: FSM returns to IDLE, `mem_req` drops at the next edge, no ready pulse. The memory model tolerates the abandoned request.
- At most one of `i_ready`/`d_ready` is high in any cycle.
- `mem_req` never deasserts before `mem_ack` except under reset.

Optional Feature:
- Macro: `ARB_STARVE_GUARD_EN`.
- With the macro:
  - A 4-bit `d_streak` counter increments on each data grant made while `i_req` is high, saturating at 15.
  - It clears on a fetch grant, or on a data grant with `i_req` low.
  - In IDLE, if `d_streak` ≥ STARVE_LIMIT and `i_req` and not `i_flush`, fetch is granted over `d_req`.
  - Reset clears `d_streak`.
- Without the macro: strict data priority and no counter logic.

Test Plan:
- Single fetch, `mem_ack` with k=2, `i_addr`=0x0000_0040, `mem_rdata`=0x0041_0113 → `mem_addr`=0x40, `mem_we`=0; `i_ready` pulses one cycle, 4 cycles after request; `i_rdata`=0x0041_0113.
- Store then load to 0x100, `d_wdata`=0xDEAD_BEEF, memory model k=0 → store: `mem_we`=1, `d_ready` pulse, `d_rdata` unchanged. Load: `d_rdata`=0xDEAD_BEEF. Each completes 2 cycles after its request.
- `i_req` and `d_req` asserted together in IDLE → data serviced first; fetch granted in the IDLE cycle after RESP; never two ready pulses in one cycle.
- Fetch in WAIT_I, `i_flush` pulsed before `mem_ack` (k=3) → `mem_req` held until ack; no `i_ready`; `i_rdata` unchanged; back to IDLE via RESP.
- Reset asserted in WAIT_D → `mem_req`=0 and all ready outputs 0 the next cycle; `busy`=0; a new `d_req` is serviced normally.
- With `ARB_STARVE_GUARD_EN`, STARVE_LIMIT=2, `d_req` and `i_req` continuously high → grant order D, D, I, D, D, I. Without the macro → D only.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency unified memory between the
//   instruction-fetch port (i_*) and the load/store data port (d_*). One memory
//   transaction is in flight at a time. The winning requester receives a
//   registered one-cycle ready pulse. The data port has fixed priority. A fetch
//   can be flushed while in flight: the memory transaction still runs to its
//   ack, but no ready pulse is returned.
//
//   Optional build macro: ARB_STARVE_GUARD_EN
//     Enables a fetch starvation guard. After STARVE_LIMIT consecutive data
//     grants that each found fetch waiting, the next grant goes to fetch.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   i_req/i_addr/i_flush           fetch request, address, pipeline redirect
//   i_ready/i_rdata                fetch ready pulse, fetched word (registered)
//   d_req/d_we/d_addr/d_wdata      data request, store enable, address, store data
//   d_ready/d_rdata                data ready pulse, load data (registered)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata              memory completion, read data in the ack cycle
//   busy                           high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [2:0] {IDLE, WAIT_I, WAIT_D, DROP, RESP} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ready_q, i_ready_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;
  logic                grant_i, grant_d;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] d_streak_q, d_streak_d;
  logic       starve;

  assign starve = (d_streak_q >= 4'(STARVE_LIMIT));

  // Streak counts data grants that left a fetch waiting; any fetch grant or a
  // data grant with no fetch pending starts the count over.
  always_comb begin
    d_streak_d = d_streak_q;
    if (grant_i) begin
      d_streak_d = '0;
    end else if (grant_d) begin
      if (!i_req)                 d_streak_d = '0;
      else if (d_streak_q != '1)  d_streak_d = d_streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) d_streak_q <= '0;
    else       d_streak_q <= d_streak_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
        if (i_req && !i_flush && (!d_req || starve)) grant_i = 1'b1;
        else if (d_req)                              grant_d = 1'b1;
`else
        if (d_req)                   grant_d = 1'b1;
        else if (i_req && !i_flush)  grant_i = 1'b1;
`endif
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = WAIT_D;
        end else if (grant_i) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          state_d    = WAIT_I;
        end
      end
      WAIT_D: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
          state_d   = RESP;
        end
      end
      WAIT_I: begin
        // A flush coinciding with the ack completes the transaction silently.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (!i_flush) begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (i_flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A behavioural memory acknowledges each
//   request after mem_k extra cycles and logs completed transactions. Expected
//   ready pulses are queued when a request is driven and popped when the DUT
//   pulses ready.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_i; logic [31:0] data; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;

  exp_t        sb[$];
  txn_t        txn_log[$];
  logic [31:0] mem[logic [31:0]];
  int          mem_k = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input bit want_i, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(want_i ? i_ready : d_ready) && cyc < 40);
    check(want_i ? "i_ready_seen" : "d_ready_seen", 32'(want_i ? i_ready : d_ready), 32'd1);
  endtask

  task automatic check_txn(input string tag, input logic we, input logic [31:0] addr);
    txn_t t;
    if (txn_log.size() == 0) begin
      check({tag, "_present"}, 32'(txn_log.size()), 32'd1);
    end else begin
      t = txn_log.pop_front();
      check({tag, "_addr"}, t.addr, addr);
      check({tag, "_we"}, 32'(t.we), 32'(we));
    end
  endtask

  // Memory model: ack mem_k cycles after the request is first seen.
  initial begin
    int cnt;
    txn_t t;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req && !reset) begin
        if (cnt >= mem_k) begin
          mem_ack   = 1'b1;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
          txn_log.push_back(t);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (i_ready || d_ready) begin
      check("dual_ready", 32'(i_ready & d_ready), 32'd0);
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("ready_port", 32'(i_ready), 32'(e.is_i));
        check("ready_data", e.is_i ? i_rdata : d_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit order_i[6];
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem[32'h40]  = 32'h0041_0113;
    mem[32'h80]  = 32'h1111_2222;
    mem[32'hC0]  = 32'h5555_5555;
    mem[32'h200] = 32'hA0A0_A0A0;
    mem[32'h300] = 32'hB0B0_B0B0;
    tick(3);
    check("rst_ctrl", 32'({mem_req, mem_we, i_ready, d_ready, busy}), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    tick(1);

    // Single fetch, k=2.
    mem_k = 2;
    sb.push_back('{1'b1, 32'h0041_0113});
    i_req = 1'b1; i_addr = 32'h40;
    wait_ready(1'b1, cyc);
    i_req = 1'b0;
    check("fetch_latency", 32'(cyc), 32'd4);
    check_txn("fetch_txn", 1'b0, 32'h40);
    tick(1);
    check("i_ready_one_cycle", 32'(i_ready), 32'd0);

    // Store then load, k=0.
    mem_k = 0;
    sb.push_back('{1'b0, 32'h0});
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    wait_ready(1'b0, cyc);
    d_req = 1'b0;
    check("store_latency", 32'(cyc), 32'd2);
    check_txn("store_txn", 1'b1, 32'h100);
    tick(1);
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    d_req = 1'b1; d_we = 1'b0;
    wait_ready(1'b0, cyc);
    d_req = 1'b0;
    check("load_latency", 32'(cyc), 32'd2);
    check_txn("load_txn", 1'b0, 32'h100);
    tick(1);

    // Simultaneous requests, k=1: data first, fetch right after RESP.
    mem_k = 1;
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    sb.push_back('{1'b1, 32'h1111_2222});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h80;
    wait_ready(1'b0, cyc);
    d_req = 1'b0;
    check("both_d_latency", 32'(cyc), 32'd3);
    wait_ready(1'b1, cyc);
    i_req = 1'b0;
    check("both_i_latency", 32'(cyc), 32'd4);
    check_txn("both_first", 1'b0, 32'h100);
    check_txn("both_second", 1'b0, 32'h80);
    tick(1);

    // Flush in WAIT_I before the ack, k=3.
    mem_k = 3;
    i_req = 1'b1; i_addr = 32'hC0;
    tick(2);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0; i_req = 1'b0;
    check("drop_mem_req", 32'(mem_req), 32'd1);
    check("drop_busy", 32'(busy), 32'd1);
    cyc = 0;
    do begin tick(1); cyc++; end while (busy && cyc < 20);
    check("drop_to_idle", 32'(cyc), 32'd3);
    check("drop_i_rdata", i_rdata, 32'h1111_2222);
    check_txn("drop_txn", 1'b0, 32'hC0);

    // Reset while in WAIT_D.
    mem_k = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick(2);
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1; d_req = 1'b0;
    tick(1);
    reset = 1'b0;
    check("post_reset_ctrl", 32'({mem_req, i_ready, d_ready, busy}), 32'd0);
    check("post_reset_d_rdata", d_rdata, 32'd0);
    mem_k = 0;
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    d_req = 1'b1;
    wait_ready(1'b0, cyc);
    d_req = 1'b0;
    check("post_reset_latency", 32'(cyc), 32'd2);
    check_txn("post_reset_txn", 1'b0, 32'h100);
    tick(1);

    // Both requests held continuously: grant order.
`ifdef ARB_STARVE_GUARD_EN
    order_i = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    order_i = '{default: 1'b0};
`endif
    for (int g = 0; g < 6; g++)
      sb.push_back('{order_i[g], order_i[g] ? 32'hA0A0_A0A0 : 32'hB0B0_B0B0});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    i_req = 1'b1; i_addr = 32'h200;
    tick(18);
    d_req = 1'b0; i_req = 1'b0;
    tick(2);
    check("order_sb_drained", 32'(sb.size()), 32'd0);
    for (int g = 0; g < 6; g++)
      check_txn($sformatf("order_%0d", g), 1'b0, order_i[g] ? 32'h200 : 32'h300);
    check("log_drained", 32'(txn_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
